// File: rtl/calc_entry_controller.sv
// Entry sequencer for the calculator: edits operands and operator from button pulses, then
// evaluates the result (add/sub in one cycle, shift-add multiply, restoring divide).
module calc_entry_controller #(
    parameter int unsigned W      = 8,
    parameter int unsigned COARSE = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn_up,
    input  logic           btn_down,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           btn_center,
    output logic [W-1:0]   a_val,
    output logic [W-1:0]   b_val,
    output logic [1:0]     op_sel,
    output logic [2*W-1:0] ans_val,
    output logic           ans_neg,
    output logic           err,
    output logic           busy,
    output logic [1:0]     field_sel
);

    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [1:0] OpAdd = 2'd0;
    localparam logic [1:0] OpSub = 2'd1;
    localparam logic [1:0] OpMul = 2'd2;
    localparam logic [1:0] OpDiv = 2'd3;

    localparam logic [1:0] FieldA   = 2'd0;
    localparam logic [1:0] FieldB   = 2'd1;
    localparam logic [1:0] FieldOp  = 2'd2;
    localparam logic [1:0] FieldAns = 2'd3;

    typedef enum logic [2:0] {
        StEditA,
        StEditB,
        StEditOp,
        StCompute,
        StShow
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2*W-1:0]  mcand_q;
    logic [2*W-1:0]  prod_q;
    logic [W-1:0]    mplier_q;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    quo_q;

    // Single-step datapath for the iterative operators
    logic [2*W-1:0]  prod_nxt;
    logic [W:0]      rem_sh;
    logic [W-1:0]    rem_nxt;
    logic            q_bit;
    logic [W-1:0]    quo_nxt;

    // One-cycle results
    logic [W:0]      sum_full;
    logic [W-1:0]    sub_mag;
    logic            sub_neg;

    always_comb begin
        prod_nxt = prod_q;
        if (mplier_q[0]) begin
            prod_nxt = prod_q + mcand_q;
        end

        rem_sh  = {rem_q, quo_q[W-1]};
        rem_nxt = rem_sh[W-1:0];
        q_bit   = 1'b0;
        if (rem_sh >= {1'b0, b_val}) begin
            rem_nxt = W'(rem_sh - {1'b0, b_val});
            q_bit   = 1'b1;
        end
        quo_nxt = {quo_q[W-2:0], q_bit};

        sum_full = {1'b0, a_val} + {1'b0, b_val};
        sub_neg  = (a_val < b_val);
        sub_mag  = sub_neg ? (b_val - a_val) : (a_val - b_val);
    end

    // Priority up > down > right > left; center is handled by the caller.
    function automatic logic [W-1:0] edit_val(input logic [W-1:0] val, input logic up,
                                              input logic down, input logic right,
                                              input logic left);
        logic [W-1:0] res;
        res = val;
        if (up) begin
            res = val + W'(1);
        end else if (down) begin
            res = val - W'(1);
        end else if (right) begin
            res = val + W'(COARSE);
        end else if (left) begin
            res = val - W'(COARSE);
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StEditA;
            a_val     <= '0;
            b_val     <= '0;
            op_sel    <= OpAdd;
            ans_val   <= '0;
            ans_neg   <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            field_sel <= FieldA;
            cnt_q     <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
        end else begin
            unique case (state_q)
                StEditA: begin
                    if (btn_center) begin
                        state_q   <= StEditB;
                        field_sel <= FieldB;
                    end else begin
                        a_val <= edit_val(a_val, btn_up, btn_down, btn_right, btn_left);
                    end
                end

                StEditB: begin
                    if (btn_center) begin
                        state_q   <= StEditOp;
                        field_sel <= FieldOp;
                    end else begin
                        b_val <= edit_val(b_val, btn_up, btn_down, btn_right, btn_left);
                    end
                end

                StEditOp: begin
                    if (btn_center) begin
                        state_q <= StCompute;
                        busy    <= 1'b1;
                        cnt_q   <= '0;
                    end else if (btn_up) begin
                        op_sel <= op_sel + 2'd1;
                    end else if (btn_down) begin
                        op_sel <= op_sel - 2'd1;
                    end else if (btn_right) begin
                        // Right outranks left but has no action here.
                        op_sel <= op_sel;
                    end else if (btn_left) begin
                        state_q   <= StEditB;
                        field_sel <= FieldB;
                    end
                end

                StCompute: begin
                    unique case (op_sel)
                        OpAdd: begin
                            ans_val   <= {{(W - 1){1'b0}}, sum_full};
                            ans_neg   <= 1'b0;
                            err       <= 1'b0;
                            state_q   <= StShow;
                            busy      <= 1'b0;
                            field_sel <= FieldAns;
                        end

                        OpSub: begin
                            ans_val   <= {{W{1'b0}}, sub_mag};
                            ans_neg   <= sub_neg;
                            err       <= 1'b0;
                            state_q   <= StShow;
                            busy      <= 1'b0;
                            field_sel <= FieldAns;
                        end

                        OpMul: begin
                            if (cnt_q == '0) begin
                                mcand_q  <= {{W{1'b0}}, a_val};
                                mplier_q <= b_val;
                                prod_q   <= '0;
                                cnt_q    <= CW'(1);
                            end else begin
                                prod_q   <= prod_nxt;
                                mcand_q  <= mcand_q << 1;
                                mplier_q <= mplier_q >> 1;
                                cnt_q    <= cnt_q + CW'(1);
                                if (cnt_q == CW'(W)) begin
                                    ans_val   <= prod_nxt;
                                    ans_neg   <= 1'b0;
                                    err       <= 1'b0;
                                    state_q   <= StShow;
                                    busy      <= 1'b0;
                                    field_sel <= FieldAns;
                                end
                            end
                        end

                        OpDiv: begin
                            if (b_val == '0) begin
                                ans_val   <= '0;
                                ans_neg   <= 1'b0;
                                err       <= 1'b1;
                                state_q   <= StShow;
                                busy      <= 1'b0;
                                field_sel <= FieldAns;
                            end else if (cnt_q == '0) begin
                                rem_q <= '0;
                                quo_q <= a_val;
                                cnt_q <= CW'(1);
                            end else begin
                                rem_q <= rem_nxt;
                                quo_q <= quo_nxt;
                                cnt_q <= cnt_q + CW'(1);
                                if (cnt_q == CW'(W)) begin
                                    ans_val   <= {{W{1'b0}}, quo_nxt};
                                    ans_neg   <= 1'b0;
                                    err       <= 1'b0;
                                    state_q   <= StShow;
                                    busy      <= 1'b0;
                                    field_sel <= FieldAns;
                                end
                            end
                        end

                        default: begin
                            state_q <= StCompute;
                        end
                    endcase
                end

                StShow: begin
                    if (btn_center) begin
                        state_q   <= StEditA;
                        field_sel <= FieldA;
                        err       <= 1'b0;
                    end
                end

                default: begin
                    state_q   <= StEditA;
                    field_sel <= FieldA;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_entry_controller.sv
// Directed bench for calc_entry_controller: editing, priority, every operator, lockout and abort.
module tb_calc_entry_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_up, btn_down, btn_left, btn_right, btn_center;
    logic [7:0]  a_val, b_val;
    logic [1:0]  op_sel;
    logic [15:0] ans_val;
    logic        ans_neg, err, busy;
    logic [1:0]  field_sel;

    int errors = 0;
    int checks = 0;

    logic [7:0] cur_a = 8'd0;
    logic [7:0] cur_b = 8'd0;
    logic [1:0] cur_op = 2'd0;

    always #5 clk = ~clk;

    calc_entry_controller #(.W(8), .COARSE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_center (btn_center),
        .a_val      (a_val),
        .b_val      (b_val),
        .op_sel     (op_sel),
        .ans_val    (ans_val),
        .ans_neg    (ans_neg),
        .err        (err),
        .busy       (busy),
        .field_sel  (field_sel)
    );

    // Button vector order: {center, up, down, right, left}
    localparam logic [4:0] BC = 5'b10000;
    localparam logic [4:0] BU = 5'b01000;
    localparam logic [4:0] BD = 5'b00100;
    localparam logic [4:0] BR = 5'b00010;

    task automatic drive(input logic [4:0] b);
        {btn_center, btn_up, btn_down, btn_right, btn_left} = b;
    endtask

    task automatic press(input logic [4:0] b);
        @(negedge clk);
        drive(b);
        @(negedge clk);
        drive(5'b0);
    endtask

    task automatic set_val(input logic [7:0] from, input logic [7:0] to);
        logic [7:0] d;
        d = to - from;
        for (int i = 0; i < int'(d[7:4]); i++) press(BR);
        for (int i = 0; i < int'(d[3:0]); i++) press(BU);
    endtask

    // From EDIT_A, leave the controller in EDIT_OP with the requested operands and operator.
    task automatic enter(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        logic [1:0] n;
        set_val(cur_a, a);
        press(BC);
        set_val(cur_b, b);
        press(BC);
        n = op - cur_op;
        for (int i = 0; i < int'(n); i++) press(BU);
        cur_a  = a;
        cur_b  = b;
        cur_op = op;
    endtask

    // Counts busy cycles; ans_val must keep its previous value throughout.
    task automatic wait_busy(output int cycles, input logic [15:0] old_ans, input bit jam);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            checks++;
            if (ans_val !== old_ans) begin
                errors++;
                $display("FAIL ans_hold cycle %0d: got %0d expected %0d", cycles, ans_val, old_ans);
            end
            drive((jam && cycles <= 3) ? 5'b11111 : 5'b0);
            @(negedge clk);
        end
        drive(5'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(5'b0);
        repeat (3) @(negedge clk);
        checks++;
        if ({a_val, b_val, op_sel, ans_val, ans_neg, err, busy, field_sel} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%0d b=%0d op=%0d ans=%0d neg=%0b err=%0b busy=%0b fs=%0d expected all 0",
                     a_val, b_val, op_sel, ans_val, ans_neg, err, busy, field_sel);
        end
        rst = 1'b1;
        repeat (3) press(BU);
        checks++;
        if (a_val !== 8'd3) begin
            errors++;
            $display("FAIL pre_reset_a: got %0d expected 3", a_val);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (a_val !== 8'd0 || field_sel !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got a=%0d fs=%0d busy=%0b expected 0 0 0", a_val, field_sel, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        press(BU);
        checks++;
        if (a_val !== 8'd1) begin
            errors++;
            $display("FAIL first_up: got %0d expected 1", a_val);
        end
        cur_a = 8'd1;
    endtask

    task automatic test_wrap_priority();
        int c;
        press(BD);
        checks++;
        if (a_val !== 8'd0) begin
            errors++;
            $display("FAIL down_to_0: got %0d expected 0", a_val);
        end
        press(BD);
        checks++;
        if (a_val !== 8'd255) begin
            errors++;
            $display("FAIL wrap_down: got %0d expected 255", a_val);
        end
        set_val(8'd255, 8'd250);
        checks++;
        if (a_val !== 8'd250) begin
            errors++;
            $display("FAIL set_250: got %0d expected 250", a_val);
        end
        press(BR);
        checks++;
        if (a_val !== 8'd10) begin
            errors++;
            $display("FAIL wrap_right: got %0d expected 10", a_val);
        end
        press(BC | BU);
        checks++;
        if (a_val !== 8'd10 || field_sel !== 2'd1) begin
            errors++;
            $display("FAIL center_priority: got a=%0d fs=%0d expected a=10 fs=1", a_val, field_sel);
        end
        press(BC);
        press(BC);
        wait_busy(c, 16'd0, 1'b0);
        checks++;
        if (c != 1 || ans_val !== 16'd10 || field_sel !== 2'd3) begin
            errors++;
            $display("FAIL add_10_0: got busy=%0d ans=%0d fs=%0d expected 1 10 3", c, ans_val, field_sel);
        end
        press(BC);
        cur_a = 8'd10;
    endtask

    task automatic test_add_sub();
        int c;
        enter(8'd200, 8'd100, 2'd0);
        press(BC);
        wait_busy(c, 16'd10, 1'b0);
        checks++;
        if (c != 1 || ans_val !== 16'd300 || ans_neg !== 1'b0 || field_sel !== 2'd3) begin
            errors++;
            $display("FAIL add_200_100: got busy=%0d ans=%0d neg=%0b fs=%0d expected 1 300 0 3",
                     c, ans_val, ans_neg, field_sel);
        end
        press(BC);
        enter(8'd5, 8'd9, 2'd1);
        press(BC);
        wait_busy(c, 16'd300, 1'b0);
        checks++;
        if (c != 1 || ans_val !== 16'd4 || ans_neg !== 1'b1) begin
            errors++;
            $display("FAIL sub_5_9: got busy=%0d ans=%0d neg=%0b expected 1 4 1", c, ans_val, ans_neg);
        end
        press(BC);
    endtask

    task automatic test_mul();
        int c;
        enter(8'd255, 8'd255, 2'd2);
        press(BC);
        wait_busy(c, 16'd4, 1'b0);
        checks++;
        if (c != 9 || ans_val !== 16'd65025 || field_sel !== 2'd3 || ans_neg !== 1'b0) begin
            errors++;
            $display("FAIL mul_255_255: got busy=%0d ans=%0d fs=%0d neg=%0b expected 9 65025 3 0",
                     c, ans_val, field_sel, ans_neg);
        end
        press(BC);
    endtask

    task automatic test_div();
        int c;
        enter(8'd200, 8'd7, 2'd3);
        press(BC);
        wait_busy(c, 16'd65025, 1'b0);
        checks++;
        if (c != 9 || ans_val !== 16'd28 || err !== 1'b0) begin
            errors++;
            $display("FAIL div_200_7: got busy=%0d ans=%0d err=%0b expected 9 28 0", c, ans_val, err);
        end
        press(BC);
        enter(8'd13, 8'd0, 2'd3);
        press(BC);
        wait_busy(c, 16'd28, 1'b0);
        checks++;
        if (c != 1 || ans_val !== 16'd0 || err !== 1'b1) begin
            errors++;
            $display("FAIL div_by_0: got busy=%0d ans=%0d err=%0b expected 1 0 1", c, ans_val, err);
        end
        press(BC);
        checks++;
        if (err !== 1'b0 || field_sel !== 2'd0 || a_val !== 8'd13) begin
            errors++;
            $display("FAIL show_exit: got err=%0b fs=%0d a=%0d expected 0 0 13", err, field_sel, a_val);
        end
    endtask

    task automatic test_lockout();
        int c;
        enter(8'd12, 8'd3, 2'd2);
        press(BC);
        wait_busy(c, 16'd0, 1'b1);
        checks++;
        if (a_val !== 8'd12 || b_val !== 8'd3 || op_sel !== 2'd2) begin
            errors++;
            $display("FAIL lockout_operands: got a=%0d b=%0d op=%0d expected 12 3 2", a_val, b_val, op_sel);
        end
        checks++;
        if (c != 9 || ans_val !== 16'd36 || field_sel !== 2'd3) begin
            errors++;
            $display("FAIL lockout_mul: got busy=%0d ans=%0d fs=%0d expected 9 36 3", c, ans_val, field_sel);
        end
        press(BC);
    endtask

    task automatic test_abort();
        enter(8'd7, 8'd7, 2'd2);
        press(BC);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_busy: got %0b expected 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({a_val, b_val, op_sel, ans_val, busy, field_sel} !== '0) begin
            errors++;
            $display("FAIL abort_reset: got a=%0d b=%0d op=%0d ans=%0d busy=%0b fs=%0d expected all 0",
                     a_val, b_val, op_sel, ans_val, busy, field_sel);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (field_sel !== 2'd0 || busy !== 1'b0 || ans_val !== 16'd0) begin
            errors++;
            $display("FAIL abort_no_show: got fs=%0d busy=%0b ans=%0d expected 0 0 0",
                     field_sel, busy, ans_val);
        end
    endtask

    initial begin
        drive(5'b0);
        rst = 1'b0;
        test_reset();
        test_wrap_priority();
        test_add_sub();
        test_mul();
        test_div();
        test_lockout();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_entry_controller.md
Name: calc_entry_controller

Overview:
Sequencing controller for the simple calculator. It turns debounced button pulses into operand A, operand B and operator entry, then runs the arithmetic: add and subtract complete in a single cycle, while multiply and divide run iteratively. It presents the A, B and ANS values to the VGA output block, along with the active-field indicator used for highlighting. It sits between the button debouncers and the VGA display controller.

Parameters:
W, 8, operand width in bits; ans_val is 2*W bits.
COARSE, 16, step applied by left/right in the operand-edit states.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
btn_up  input  1  single-cycle debounced pulse.
btn_down  input  1  single-cycle debounced pulse.
btn_left  input  1  single-cycle debounced pulse.
btn_right  input  1  single-cycle debounced pulse.
btn_center  input  1  single-cycle debounced pulse; advances to the next step.
a_val  output  W  operand A.
b_val  output  W  operand B.
op_sel  output  2  operator: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
ans_val  output  2*W  result magnitude.
ans_neg  output  1  result is negative (SUB only).
err  output  1  divide by zero.
busy  output  1  high in every COMPUTE cycle.
field_sel  output  2  active field: 0 A, 1 B, 2 OP, 3 ANS.

Behaviour:
- Reset (rst low, asynchronous):
  - state = EDIT_A.
  - All outputs are 0.
  - Internal accumulators and iteration counter are cleared.
  - Applies at any point, including mid-COMPUTE; the operation in progress is aborted with no partial result.
- States and field_sel: EDIT_A (0), EDIT_B (1), EDIT_OP (2), COMPUTE (holds 2), SHOW (3).
- Button priority when several pulses coincide: center > up > down > right > left. Exactly one action per cycle.
- EDIT_A and EDIT_B (act on a_val or b_val, arithmetic modulo 2^W):
  - up: +1.
  - down: -1.
  - right: +COARSE.
  - left: -COARSE.
  - center: EDIT_A goes to EDIT_B; EDIT_B goes to EDIT_OP.
- EDIT_OP:
  - up: op_sel +1 mod 4.
  - down: op_sel -1 mod 4.
  - left: return to EDIT_B.
  - right: ignored.
  - center: go to COMPUTE.
- COMPUTE:
  - All buttons ignored.
  - a_val, b_val and op_sel are frozen.
  - ans_val, ans_neg and err keep their previous values until completion, then update together in the same cycle the state enters SHOW.
- ADD: one COMPUTE cycle. ans_val = a+b, zero-extended to 2W; ans_neg = 0.
- SUB: one COMPUTE cycle.
  - a >= b: ans_val = a-b, ans_neg = 0.
  - a < b: ans_val = b-a, ans_neg = 1.
- MUL: shift-add, W+1 COMPUTE cycles (1 load cycle + W iterations). ans_val = a*b, full 2W-bit product, no overflow possible.
- DIV with b != 0: restoring division, W+1 COMPUTE cycles.
  - ans_val = floor(a/b), zero-extended.
  - Remainder is discarded.
  - ans_neg = 0, err = 0.
- DIV with b == 0: one COMPUTE cycle. ans_val = 0, err = 1.
- Busy timing: busy is 1 exactly in COMPUTE cycles and 0 otherwise.
- SHOW:
  - up, down, left and right are ignored.
  - center: go to EDIT_A and clear err.
  - a_val, b_val, op_sel and ans_val are retained, so the next entry edits from the previous operands.
- Pulses arriving in the same cycle as a state change are evaluated against the pre-transition state only.

Test Plan:
1. Reset: hold rst low mid-run, then release -> all outputs 0, field_sel=0, busy=0; first btn_up -> a_val=1.
2. Wrap and priority:
   - a_val=0, btn_down -> 255.
   - a_val=250, btn_right -> 10.
   - btn_up together with btn_center in EDIT_A -> a_val unchanged, field_sel=1.
3. ADD and SUB:
   - 200 ADD 100 -> busy high 1 cycle, ans_val=300, ans_neg=0.
   - 5 SUB 9 -> ans_val=4, ans_neg=1.
4. MUL: 255 MUL 255 -> busy high exactly 9 cycles, then ans_val=65025, field_sel=3; ans_val holds its old value during busy.
5. DIV:
   - 200 DIV 7 -> busy 9 cycles, ans_val=28, err=0.
   - 13 DIV 0 -> busy 1 cycle, ans_val=0, err=1.
   - btn_center in SHOW -> err=0, field_sel=0, a_val=13 retained.
6. Abort and lockout: assert rst on the 4th cycle of a MUL -> immediate reset values, no SHOW entry; button pulses during COMPUTE change nothing.
